// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the display timing / pixel unpacker block:
//   - disp_state_t  : run/idle state encoding of the timing engine
//   - disp_timing_t : one complete set of horizontal/vertical timing fields
//   - TIMING_*      : standard VESA/CEA timing sets (active/fp/sync/bp, polarity)
// -----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } disp_state_t;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } disp_timing_t;

    // 640x480 @ 60 Hz, negative syncs
    localparam disp_timing_t TIMING_VGA  = '{16'd640,  16'd16,  16'd96,  16'd48,
                                             16'd480,  16'd10,  16'd2,   16'd33,  1'b0, 1'b0};
    // 800x600 @ 60 Hz, positive syncs
    localparam disp_timing_t TIMING_SVGA = '{16'd800,  16'd40,  16'd128, 16'd88,
                                             16'd600,  16'd1,   16'd4,   16'd23,  1'b1, 1'b1};
    // 1024x768 @ 60 Hz, negative syncs
    localparam disp_timing_t TIMING_XGA  = '{16'd1024, 16'd24,  16'd136, 16'd160,
                                             16'd768,  16'd3,   16'd6,   16'd29,  1'b0, 1'b0};
    // 1280x1024 @ 60 Hz, positive syncs
    localparam disp_timing_t TIMING_SXGA = '{16'd1280, 16'd48,  16'd112, 16'd248,
                                             16'd1024, 16'd1,   16'd3,   16'd38,  1'b1, 1'b1};
    // 1280x720 @ 60 Hz, positive syncs
    localparam disp_timing_t TIMING_HD   = '{16'd1280, 16'd110, 16'd40,  16'd220,
                                             16'd720,  16'd5,   16'd5,   16'd20,  1'b1, 1'b1};

endpackage

// File: rtl/disp_axis_counter.sv
// -----------------------------------------------------------------------------
// disp_axis_counter
// One display axis (horizontal or vertical): a position counter that wraps at
// active+fp+sync+bp-1, plus the active-region and sync-window decodes.
// Ports:
//   clk_disp, reset_disp : clock, synchronous active-high reset
//   clr                  : hold the count at 0 (wins over inc)
//   inc                  : advance the count this cycle
//   len_active/fp/sync/bp: segment lengths for this axis
//   count                : current position
//   wrap                 : inc is high and this is the last position of the axis
//   in_active            : count < len_active
//   in_sync              : count inside [active+fp, active+fp+sync-1]
// -----------------------------------------------------------------------------
module disp_axis_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_disp,
    input  logic             reset_disp,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] len_active,
    input  logic [CNT_W-1:0] len_fp,
    input  logic [CNT_W-1:0] len_sync,
    input  logic [CNT_W-1:0] len_bp,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             in_active,
    output logic             in_sync
);

    // Two guard bits: the sum of four CNT_W-bit fields cannot overflow.
    localparam int SUM_W = CNT_W + 2;

    logic [SUM_W-1:0] total;
    logic [SUM_W-1:0] sync_start;
    logic [SUM_W-1:0] sync_end;
    logic [SUM_W-1:0] count_ext;

    assign sync_start = SUM_W'(len_active) + SUM_W'(len_fp);
    assign sync_end   = sync_start + SUM_W'(len_sync);
    assign total      = sync_end + SUM_W'(len_bp);
    assign count_ext  = SUM_W'(count);

    // ">=" rather than "==" so an all-zero axis wraps every cycle instead of
    // running through the whole counter range.
    assign wrap      = inc && ((count_ext + SUM_W'(1)) >= total);
    assign in_active = (count < len_active);
    // An empty sync field gives sync_start == sync_end: the window never opens.
    assign in_sync   = (count_ext >= sync_start) && (count_ext < sync_end);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_disp) begin
        if (reset_disp || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/disp_timing_unpacker.sv
// -----------------------------------------------------------------------------
// disp_timing_unpacker
// Display timing generator that unpacks PPW = DATA_W/PIX_W pixels per word from
// a first-word-fall-through FIFO (DATA_W must be a multiple of PIX_W).
// Timing fields are shadowed while idle and at each frame origin, so changes
// take effect at a frame boundary. Colour, syncs, display_enable and
// frame_start leave through a 2-stage register pipeline.
// Ports:
//   clk_disp, reset_disp      : clock, synchronous active-high reset
//   enable                    : run timing; low returns to idle next cycle
//   h_*/v_*, hs_pol/vs_pol    : timing fields and sync active levels
//   fifo_dout/fifo_empty      : FWFT FIFO head word and empty flag
//   fifo_rd_en                : pop, high while the last lane of a word is used
//   red/green/blue_out        : pixel colour (pixel bits [23:16]/[15:8]/[7:0])
//   hsync, vsync              : sync outputs
//   display_enable            : active video
//   frame_start               : one-cycle pulse with the first pixel of a frame
//   underflow, underflow_clr  : sticky starvation flag and its clear
// -----------------------------------------------------------------------------
module disp_timing_unpacker
    import disp_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 64,
    parameter int PIX_W  = 32
) (
    input  logic              clk_disp,
    input  logic              reset_disp,
    input  logic              enable,
    input  logic [CNT_W-1:0]  h_active,
    input  logic [CNT_W-1:0]  h_fp,
    input  logic [CNT_W-1:0]  h_sync,
    input  logic [CNT_W-1:0]  h_bp,
    input  logic [CNT_W-1:0]  v_active,
    input  logic [CNT_W-1:0]  v_fp,
    input  logic [CNT_W-1:0]  v_sync,
    input  logic [CNT_W-1:0]  v_bp,
    input  logic              hs_pol,
    input  logic              vs_pol,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [7:0]        red_out,
    output logic [7:0]        green_out,
    output logic [7:0]        blue_out,
    output logic              hsync,
    output logic              vsync,
    output logic              display_enable,
    output logic              frame_start,
    output logic              underflow,
    input  logic              underflow_clr
);

    localparam int PPW    = DATA_W / PIX_W;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPW - 1);

    disp_state_t      state_q, state_d;
    logic [CNT_W-1:0] sh_h_active, sh_h_fp, sh_h_sync, sh_h_bp;
    logic [CNT_W-1:0] sh_v_active, sh_v_fp, sh_v_sync, sh_v_bp;
    logic             sh_hs_pol, sh_vs_pol;
    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap, v_wrap, h_act, v_act, h_sync_win, v_sync_win;
    logic             run, count_en, frame_origin;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic             need_pix, starve, consume, rd_en;
    logic [PIX_W-1:0] lanes [PPW];
    logic [PIX_W-1:0] pix;

    // Stage-1 and stage-2 output pipeline.
    logic [23:0] rgb_s1, rgb_s2;
    logic        de_s1, de_s2, hs_s1, hs_s2, vs_s1, vs_s2, fs_s1, fs_s2;

    assign run          = (state_q == ST_RUN);
    assign count_en     = run && enable;
    assign frame_origin = (h_count == '0) && (v_count == '0);

    always_comb begin
        for (int k = 0; k < PPW; k++) begin
            lanes[k] = fifo_dout[PIX_W*k +: PIX_W];
        end
    end
    assign pix = lanes[lane_q];

    always_ff @(posedge clk_disp) begin
        if (reset_disp) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        need_pix = 1'b0;
        starve   = 1'b0;
        consume  = 1'b0;
        rd_en    = 1'b0;
        lane_d   = lane_q;
        case (state_q)
            ST_IDLE: if (enable && !fifo_empty) state_d = ST_RUN;
            ST_RUN: begin
                if (!enable) state_d = ST_IDLE;
                need_pix = h_act && v_act;
                starve   = need_pix && fifo_empty;
                consume  = need_pix && !fifo_empty;
                // Pop in the same cycle the FWFT head supplies its last lane.
                rd_en    = consume && (lane_q == LAST_LANE);
                if (consume) lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        // Realign to lane 0 for the next frame and whenever counting stops.
        if (!count_en || v_wrap) lane_d = '0;
    end

    // A reset arriving mid-word must not pop a word that was never shown.
    assign fifo_rd_en = rd_en && !reset_disp;

    // While idle the counters sit at 0, so frame_origin also covers idle capture.
    always_ff @(posedge clk_disp) begin
        if (reset_disp) begin
            {sh_h_active, sh_h_fp, sh_h_sync, sh_h_bp} <= '0;
            {sh_v_active, sh_v_fp, sh_v_sync, sh_v_bp} <= '0;
            {sh_hs_pol, sh_vs_pol}                     <= '0;
        end else if (frame_origin) begin
            {sh_h_active, sh_h_fp, sh_h_sync, sh_h_bp} <= {h_active, h_fp, h_sync, h_bp};
            {sh_v_active, sh_v_fp, sh_v_sync, sh_v_bp} <= {v_active, v_fp, v_sync, v_bp};
            {sh_hs_pol, sh_vs_pol}                     <= {hs_pol, vs_pol};
        end
    end

    disp_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
        .clk_disp   (clk_disp),
        .reset_disp (reset_disp),
        .clr        (!count_en),
        .inc        (count_en),
        .len_active (sh_h_active),
        .len_fp     (sh_h_fp),
        .len_sync   (sh_h_sync),
        .len_bp     (sh_h_bp),
        .count      (h_count),
        .wrap       (h_wrap),
        .in_active  (h_act),
        .in_sync    (h_sync_win)
    );

    disp_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
        .clk_disp   (clk_disp),
        .reset_disp (reset_disp),
        .clr        (!count_en),
        .inc        (h_wrap),
        .len_active (sh_v_active),
        .len_fp     (sh_v_fp),
        .len_sync   (sh_v_sync),
        .len_bp     (sh_v_bp),
        .count      (v_count),
        .wrap       (v_wrap),
        .in_active  (v_act),
        .in_sync    (v_sync_win)
    );

    always_ff @(posedge clk_disp) begin
        if (reset_disp) lane_q <= '0;
        else            lane_q <= lane_d;
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk_disp) begin
        if (reset_disp)         underflow <= 1'b0;
        else if (starve)        underflow <= 1'b1;
        else if (underflow_clr) underflow <= 1'b0;
    end

    always_ff @(posedge clk_disp) begin
        if (reset_disp) begin
            {rgb_s1, de_s1, hs_s1, vs_s1, fs_s1} <= {24'h0, 1'b0, 1'b1, 1'b1, 1'b0};
            {rgb_s2, de_s2, hs_s2, vs_s2, fs_s2} <= {24'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        end else begin
            // Starved pixels and blanking both come out black.
            rgb_s1 <= consume ? pix[23:0] : 24'h0;
            de_s1  <= need_pix;
            hs_s1  <= (run && h_sync_win) ? sh_hs_pol : !sh_hs_pol;
            vs_s1  <= (run && v_sync_win) ? sh_vs_pol : !sh_vs_pol;
            fs_s1  <= run && frame_origin;
            {rgb_s2, de_s2, hs_s2, vs_s2, fs_s2} <= {rgb_s1, de_s1, hs_s1, vs_s1, fs_s1};
        end
    end

    assign {red_out, green_out, blue_out} = rgb_s2;
    assign display_enable = de_s2;
    assign hsync          = hs_s2;
    assign vsync          = vs_s2;
    assign frame_start    = fs_s2;

endmodule

// File: tb/tb_disp_timing_unpacker.sv
// -----------------------------------------------------------------------------
// tb_disp_timing_unpacker
// Directed and randomized stimulus for disp_timing_unpacker. A frame-level
// reference model (pixel position, lane, shadowed fields, two-deep output
// delay) predicts every output each cycle; a queue plays the FWFT FIFO.
// -----------------------------------------------------------------------------
module tb_disp_timing_unpacker;

    localparam int CNT_W  = 16;
    localparam int DATA_W = 64;
    localparam int PIX_W  = 32;
    localparam int PPW    = DATA_W / PIX_W;

    logic              clk_disp = 1'b0;
    logic              reset_disp, enable, underflow_clr;
    logic [CNT_W-1:0]  h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp;
    logic              hs_pol, vs_pol;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty, fifo_rd_en;
    logic [7:0]        red_out, green_out, blue_out;
    logic              hsync, vsync, display_enable, frame_start, underflow;

    always #5 clk_disp = ~clk_disp;

    disp_timing_unpacker #(.CNT_W(CNT_W), .DATA_W(DATA_W), .PIX_W(PIX_W)) dut (
        .clk_disp       (clk_disp),
        .reset_disp     (reset_disp),
        .enable         (enable),
        .h_active       (h_active),
        .h_fp           (h_fp),
        .h_sync         (h_sync),
        .h_bp           (h_bp),
        .v_active       (v_active),
        .v_fp           (v_fp),
        .v_sync         (v_sync),
        .v_bp           (v_bp),
        .hs_pol         (hs_pol),
        .vs_pol         (vs_pol),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .red_out        (red_out),
        .green_out      (green_out),
        .blue_out       (blue_out),
        .hsync          (hsync),
        .vsync          (vsync),
        .display_enable (display_enable),
        .frame_start    (frame_start),
        .underflow      (underflow),
        .underflow_clr  (underflow_clr)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DATA_W-1:0] fq [$];
    bit   force_empty = 1'b0;
    bit   auto_fill   = 1'b0;
    logic last_rd;

    // Reference model state.
    typedef struct packed {
        logic [23:0] rgb;
        logic        de, hs, vs, fs;
    } exp_t;
    localparam exp_t RST_OUT = '{24'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t s1, s2;
    bit   m_run, m_uf, exp_rd, sh_hp, sh_vp;
    int   m_h, m_v, m_lane;
    int   sh [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_timing(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
        h_active = CNT_W'(ha); h_fp = CNT_W'(hf); h_sync = CNT_W'(hs); h_bp = CNT_W'(hb);
        v_active = CNT_W'(va); v_fp = CNT_W'(vf); v_sync = CNT_W'(vs); v_bp = CNT_W'(vb);
        hs_pol = hp; vs_pol = vp;
    endtask

    function automatic bit model_active();
        return m_run && (m_h < sh[0]) && (m_v < sh[4]);
    endfunction

    // One display clock of the reference model, using this cycle's inputs.
    task automatic model_step();
        exp_t cur;
        logic [DATA_W-1:0] w;
        bit   act, set_uf, at_origin;
        int   hsum, vsum;
        exp_rd = 1'b0;
        if (reset_disp) begin
            m_run = 0; m_h = 0; m_v = 0; m_lane = 0; m_uf = 0;
            foreach (sh[i]) sh[i] = 0;
            sh_hp = 0; sh_vp = 0;
            s1 = RST_OUT; s2 = RST_OUT;
            return;
        end
        cur    = '{24'h0, 1'b0, !sh_hp, !sh_vp, 1'b0};
        set_uf = 1'b0;
        if (m_run) begin
            act    = model_active();
            cur.de = act;
            cur.fs = (m_h == 0) && (m_v == 0);
            if (m_h >= sh[0] + sh[1] && m_h < sh[0] + sh[1] + sh[2]) cur.hs = sh_hp;
            if (m_v >= sh[4] + sh[5] && m_v < sh[4] + sh[5] + sh[6]) cur.vs = sh_vp;
            if (act) begin
                if (fifo_empty) set_uf = 1'b1;
                else begin
                    w       = fifo_dout >> (PIX_W * m_lane);
                    cur.rgb = w[23:0];
                    if (m_lane == PPW - 1) begin exp_rd = 1'b1; m_lane = 0; end
                    else m_lane++;
                end
            end
        end
        if (set_uf) m_uf = 1'b1;
        else if (underflow_clr) m_uf = 1'b0;
        s2 = s1;
        s1 = cur;
        hsum      = sh[0] + sh[1] + sh[2] + sh[3];
        vsum      = sh[4] + sh[5] + sh[6] + sh[7];
        at_origin = (m_h == 0) && (m_v == 0);
        if (!m_run) begin
            if (enable && !fifo_empty) m_run = 1'b1;
        end else if (!enable) begin
            m_run = 0; m_h = 0; m_v = 0; m_lane = 0;
        end else begin
            m_h++;
            if (m_h >= hsum) begin
                m_h = 0;
                m_v++;
                if (m_v >= vsum) begin m_v = 0; m_lane = 0; end
            end
        end
        if (at_origin) begin
            sh[0] = int'(h_active); sh[1] = int'(h_fp); sh[2] = int'(h_sync); sh[3] = int'(h_bp);
            sh[4] = int'(v_active); sh[5] = int'(v_fp); sh[6] = int'(v_sync); sh[7] = int'(v_bp);
            sh_hp = hs_pol; sh_vp = vs_pol;
        end
    endtask

    // Apply one clock: present FIFO head, predict, check pop, clock, check outputs.
    task automatic cycle();
        fifo_empty = force_empty || (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : {$urandom(), $urandom()};
        #2;
        model_step();
        last_rd = fifo_rd_en;
        check("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
        @(posedge clk_disp);
        if (last_rd && !fifo_empty) void'(fq.pop_front());
        #1;
        cyc++;
        check("rgb",            64'({red_out, green_out, blue_out}), 64'(s2.rgb));
        check("display_enable", 64'(display_enable), 64'(s2.de));
        check("hsync",          64'(hsync),          64'(s2.hs));
        check("vsync",          64'(vsync),          64'(s2.vs));
        check("frame_start",    64'(frame_start),    64'(s2.fs));
        check("underflow",      64'(underflow),      64'(m_uf));
        if (auto_fill) while (fq.size() < 4) fq.push_back({$urandom(), $urandom()});
    endtask

    task automatic wait_frame_start(input string tag);
        int n = 0;
        while (frame_start !== 1'b1 && n < 300) begin cycle(); n++; end
        check(tag, 64'(frame_start), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"},   64'({red_out, green_out, blue_out}), 64'(0));
        check({tag, "_de"},    64'(display_enable), 64'(0));
        check({tag, "_hsync"}, 64'(hsync), 64'(1));
        check({tag, "_vsync"}, 64'(vsync), 64'(1));
        check({tag, "_fs"},    64'(frame_start), 64'(0));
        check({tag, "_uf"},    64'(underflow), 64'(0));
    endtask

    initial begin
        int n, hs_low, rd_cnt, fs_gap, c0, sync_hits;

        // Reset state.
        reset_disp = 1'b1; enable = 1'b0; underflow_clr = 1'b0;
        set_timing(8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0);
        repeat (2) cycle();
        check_reset_outputs("reset");
        reset_disp = 1'b0;

        // First word split into lanes: lane 0 then lane 1.
        fq.push_back(64'hAABB_CCDD_1122_3344);
        auto_fill = 1'b1;
        enable    = 1'b1;
        wait_frame_start("first_frame_start");
        check("pixel0_rgb", 64'({red_out, green_out, blue_out}), 64'h22_3344);
        cycle();
        check("pixel1_rgb", 64'({red_out, green_out, blue_out}), 64'hBB_CCDD);

        // Steady-state frame: sync duty, pop rate, frame period.
        wait_frame_start("second_frame_start");
        c0 = cyc; hs_low = 0; rd_cnt = 0; fs_gap = 0;
        for (int i = 0; i < 98; i++) begin
            cycle();
            if (i < 14 && hsync == 1'b0) hs_low++;
            if (last_rd) rd_cnt++;
            if (frame_start && fs_gap == 0) fs_gap = cyc - c0;
        end
        check("hsync_low_per_line", 64'(hs_low), 64'(2));
        check("pops_per_frame",     64'(rd_cnt), 64'(16));
        check("frame_period",       64'(fs_gap), 64'(98));

        // Starvation for 3 active pixels, then resume.
        n = 0;
        while (!(model_active() && m_h + 2 < sh[0]) && n < 200) begin cycle(); n++; end
        check("starve_window_found", 64'(model_active()), 64'(1));
        force_empty = 1'b1;
        repeat (3) cycle();
        force_empty = 1'b0;
        check("underflow_set", 64'(underflow), 64'(1));
        repeat (4) cycle();
        check("underflow_sticky", 64'(underflow), 64'(1));
        underflow_clr = 1'b1;
        cycle();
        underflow_clr = 1'b0;
        check("underflow_cleared", 64'(underflow), 64'(0));

        // Clear and new starvation together: set wins.
        n = 0;
        while (!model_active() && n < 200) begin cycle(); n++; end
        force_empty = 1'b1; underflow_clr = 1'b1;
        cycle();
        force_empty = 1'b0; underflow_clr = 1'b0;
        check("underflow_set_wins", 64'(underflow), 64'(1));
        underflow_clr = 1'b1; cycle(); underflow_clr = 1'b0;

        // Mid-frame h_active change: old line length holds until the frame origin.
        repeat (20) cycle();
        h_active = CNT_W'(6);
        repeat (250) cycle();

        // Enable dropped mid-line, then re-enabled.
        n = 0;
        while (!(m_run && m_v == 1 && m_h == 3) && n < 200) begin cycle(); n++; end
        enable = 1'b0;
        cycle();
        repeat (3) cycle();
        check("idle_de", 64'(display_enable), 64'(0));
        enable = 1'b1;
        cycle();
        cycle();
        check("reenable_fs_early", 64'(frame_start), 64'(0));
        cycle();
        check("reenable_fs_at_2", 64'(frame_start), 64'(1));

        // Reset during the active region, on a cycle that would otherwise pop.
        n = 0;
        while (!(model_active() && m_lane == PPW - 1 && m_h > 1) && n < 300) begin cycle(); n++; end
        reset_disp = 1'b1;
        cycle();
        check("reset_no_pop", 64'(last_rd), 64'(0));
        check_reset_outputs("midframe_reset");
        reset_disp = 1'b0;

        // Zero-width sync fields: no sync pulse, counters keep running.
        set_timing(6, 2, 0, 2, 3, 1, 0, 1, 1'b0, 1'b0);
        repeat (60) cycle();
        sync_hits = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (hsync == 1'b0 || vsync == 1'b0) sync_hits++;
        end
        check("zero_sync_no_pulse", 64'(sync_hits), 64'(0));
        wait_frame_start("zero_sync_frames_run");

        // Randomized timing, FIFO starvation, clears and enable drops.
        for (int t = 0; t < 6; t++) begin
            set_timing($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 2),
                       $urandom_range(0, 2), $urandom_range(0, 2),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 300; i++) begin
                force_empty   = ($urandom_range(0, 7) == 0);
                underflow_clr = ($urandom_range(0, 15) == 0);
                enable        = ($urandom_range(0, 49) != 0);
                cycle();
            end
        end
        force_empty = 1'b0; underflow_clr = 1'b0; enable = 1'b1;
        repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
